// File: rtl/disp_pkg.sv
// Shared types and constants for the 4-digit 7-segment display path.
package disp_pkg;

  localparam int DISP_DIGITS = 4;
  localparam logic [3:0] DISP_BLANK_AN = 4'b1111;

  typedef logic [4*DISP_DIGITS-1:0] disp_word_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_SHOW = 2'd1,
    ARB_GAP  = 2'd2
  } arb_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/disp_share_arb_if.sv
// Client-side bus of the display time-sharing arbiter: requests and words in,
// grant status and display bytes out.
interface disp_share_arb_if #(
  parameter int N_REQ = 4
);
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]    req;
  logic [16*N_REQ-1:0] data;
  logic [N_REQ-1:0]    gnt;
  logic [IW-1:0]       src;
  logic                done;
  logic [7:0]          HB;
  logic [7:0]          LB;
  logic                blank;
  logic                busy;

  // Clients drive requests and words.
  modport master (
    output req, data,
    input  gnt, src, done, HB, LB, blank, busy
  );

  // The arbiter drives grant status and display bytes.
  modport slave (
    input  req, data,
    output gnt, src, done, HB, LB, blank, busy
  );

endinterface

// File: rtl/disp_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module disp_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IW-1:0]    idx,
  output logic             any
);

  always_comb begin
    logic [IW-1:0] cand;
    // NOTE: every output gets a default before the loop so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IW'((int'(ptr) + k) % N_REQ);
      if (!any && req[cand]) begin
        any          = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/disp_share_arb.sv
// Round-robin time-sharing arbiter feeding HB/LB of the 7-segment driver.
// Define DISP_ARB_GAP_EN to add a blanked gap between consecutive owners.
import disp_pkg::*;

module disp_share_arb #(
  parameter int N_REQ    = 4,
  parameter int Fclk     = 50000,
  parameter int DWELL_MS = 500,
  parameter int GAP_MS   = 50
) (
  input logic            clk,
  input logic            rst_n,
  disp_share_arb_if.slave bus
);

  localparam int IW = $clog2(N_REQ);
  localparam int PW = $clog2(Fclk + 1);
  localparam int DW = $clog2(max_int(DWELL_MS, GAP_MS) + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(Fclk - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_MS - 1);
  localparam logic [IW-1:0] PTR_LAST   = IW'(N_REQ - 1);
`ifdef DISP_ARB_GAP_EN
  localparam logic [DW-1:0] GAP_LAST   = DW'(GAP_MS - 1);
`endif

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    src_q, src_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  disp_word_t       word_q, word_d;
  logic             done_q, done_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic             blank_q, blank_d;

  logic             tick;
  logic             own_req;
  logic             others_req;
  logic             dwell_end;
  disp_word_t       words [N_REQ];

  logic [N_REQ-1:0] pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign words[i] = bus.data[16*i +: 16];
  end

  disp_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // The prescaler wraps on its Fclk-th cycle; that edge is the 1 ms tick.
  assign tick       = (presc_q == PRESC_LAST);
  assign own_req    = bus.req[src_q];
  assign others_req = |(bus.req & ~gnt_q);
  assign dwell_end  = tick && (dwell_q == DWELL_LAST);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    src_d   = src_q;
    gnt_d   = gnt_q;
    word_d  = word_q;
    done_d  = 1'b0;
    presc_d = presc_q;
    dwell_d = dwell_q;
    blank_d = blank_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_onehot;
          src_d   = pick_idx;
          word_d  = words[pick_idx];
          presc_d = '0;
          dwell_d = '0;
          state_d = ARB_SHOW;
        end
      end

      ARB_SHOW: begin
        word_d  = words[src_q];
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) dwell_d = dwell_q + DW'(1);

        // A sole remaining requester keeps the display without a done pulse.
        if (!own_req || (dwell_end && others_req)) begin
          gnt_d   = '0;
          done_d  = 1'b1;
          ptr_d   = (src_q == PTR_LAST) ? '0 : src_q + IW'(1);
          presc_d = '0;
          dwell_d = '0;
`ifdef DISP_ARB_GAP_EN
          blank_d = 1'b1;
          state_d = ARB_GAP;
`else
          state_d = ARB_IDLE;
`endif
        end else if (dwell_end) begin
          dwell_d = '0;
        end
      end

`ifdef DISP_ARB_GAP_EN
      ARB_GAP: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          if (dwell_q == GAP_LAST) begin
            dwell_d = '0;
            blank_d = 1'b0;
            state_d = ARB_IDLE;
          end else begin
            dwell_d = dwell_q + DW'(1);
          end
        end
      end
`endif

      default: state_d = ARB_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values; rst_n clears them asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      src_q   <= '0;
      gnt_q   <= '0;
      word_q  <= '0;
      done_q  <= 1'b0;
      presc_q <= '0;
      dwell_q <= '0;
      blank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      gnt_q   <= gnt_d;
      word_q  <= word_d;
      done_q  <= done_d;
      presc_q <= presc_d;
      dwell_q <= dwell_d;
      blank_q <= blank_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.src  = src_q;
  assign bus.done = done_q;
  assign bus.HB   = word_q[15:8];
  assign bus.LB   = word_q[7:0];
  assign bus.busy = (state_q != ARB_IDLE);
`ifdef DISP_ARB_GAP_EN
  assign bus.blank = blank_q;
`else
  assign bus.blank = 1'b0;
`endif

endmodule

// File: tb/tb_disp_share_arb.sv
// Directed bench for disp_share_arb: N_REQ=4, Fclk=4, DWELL_MS=3, GAP_MS=2.
module tb_disp_share_arb;

  localparam int N_REQ = 4;
  localparam int DWELL = 12;
`ifdef DISP_ARB_GAP_EN
  localparam int HAND  = 21;
  localparam logic GAP_ON = 1'b1;
`else
  localparam int HAND  = 13;
  localparam logic GAP_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  logic [15:0] rr_word [N_REQ];

  disp_share_arb_if #(.N_REQ(N_REQ)) bus ();

  disp_share_arb #(
    .N_REQ    (N_REQ),
    .Fclk     (4),
    .DWELL_MS (3),
    .GAP_MS   (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_rr_words();
    for (int i = 0; i < N_REQ; i++) bus.data[16*i +: 16] = rr_word[i];
  endtask

  initial begin
    logic       done_seen;
    logic       gnt_moved;
    logic [3:0] oh;
    int         own;
    int         prev;

    n_checks = 0;
    n_err    = 0;
    rr_word[0] = 16'h10F0;
    rr_word[1] = 16'h21E1;
    rr_word[2] = 16'h32D2;
    rr_word[3] = 16'h43C3;

    // Reset with random activity on the inputs.
    rst_n    = 1'b0;
    bus.req  = 4'($urandom);
    bus.data = {$urandom, $urandom};
    step(3);
    check("rst_gnt",   32'(bus.gnt),   32'h0);
    check("rst_src",   32'(bus.src),   32'h0);
    check("rst_done",  32'(bus.done),  32'h0);
    check("rst_hb_lb", {bus.HB, bus.LB}, 32'h0);
    check("rst_blank", 32'(bus.blank), 32'h0);
    check("rst_busy",  32'(bus.busy),  32'h0);

    bus.req = '0;
    rst_n   = 1'b1;
    step(3);
    check("idle_busy", 32'(bus.busy), 32'h0);
    check("idle_gnt",  32'(bus.gnt),  32'h0);

    // Single client 2 with word 1234.
    load_rr_words();
    bus.data[47:32] = 16'h1234;
    bus.req = 4'b0100;
    step(1);
    check("single_gnt",  32'(bus.gnt),  32'h4);
    check("single_src",  32'(bus.src),  32'h2);
    check("single_hb",   32'(bus.HB),   32'h12);
    check("single_lb",   32'(bus.LB),   32'h34);
    check("single_busy", 32'(bus.busy), 32'h1);

    done_seen = 1'b0;
    gnt_moved = 1'b0;
    for (int c = 0; c < DWELL + 3; c++) begin
      step(1);
      if (bus.done) done_seen = 1'b1;
      if (bus.gnt != 4'b0100) gnt_moved = 1'b1;
    end
    check("hold_no_done", 32'(done_seen), 32'h0);
    check("hold_gnt",     32'(gnt_moved), 32'h0);

    // Live follow of the owner's word.
    bus.data[47:32] = 16'hBEEF;
    step(1);
    check("live_beef", {bus.HB, bus.LB}, 32'hBEEF);
    bus.data[47:32] = 16'hCAFE;
    step(1);
    check("live_cafe", {bus.HB, bus.LB}, 32'hCAFE);
    check("live_gnt",  32'(bus.gnt), 32'h4);

    // Asynchronous reset between edges while showing.
    #2 rst_n = 1'b0;
    #1;
    check("areset_gnt",   32'(bus.gnt),   32'h0);
    check("areset_hblb",  {bus.HB, bus.LB}, 32'h0);
    check("areset_blank", 32'(bus.blank), 32'h0);
    check("areset_done",  32'(bus.done),  32'h0);
    check("areset_busy",  32'(bus.busy),  32'h0);
    step(1);
    check("areset_done2", 32'(bus.done), 32'h0);

    // Restart with everyone requesting: owners 0,1,2,3,0.
    load_rr_words();
    bus.req = 4'b1111;
    rst_n   = 1'b1;
    step(1);
    check("rr0_gnt", 32'(bus.gnt), 32'h1);
    check("rr0_src", 32'(bus.src), 32'h0);
    check("rr0_hb",  32'(bus.HB),  32'h10);

    for (int k = 1; k <= 4; k++) begin
      prev = (k - 1) % N_REQ;
      own  = k % N_REQ;
      step(DWELL - 1);
      oh = 4'b0001 << prev;
      check($sformatf("rr%0d_held", k), 32'(bus.gnt), 32'(oh));
      step(1);
      check($sformatf("rr%0d_done", k),   32'(bus.done),  32'h1);
      check($sformatf("rr%0d_gnt_off", k), 32'(bus.gnt),  32'h0);
      check($sformatf("rr%0d_blank", k),  32'(bus.blank), 32'(GAP_ON));
      step(HAND - DWELL);
      oh = 4'b0001 << own;
      check($sformatf("rr%0d_gnt", k),   32'(bus.gnt),   32'(oh));
      check($sformatf("rr%0d_src", k),   32'(bus.src),   32'(own));
      check($sformatf("rr%0d_word", k),  {bus.HB, bus.LB}, 32'(rr_word[own]));
      check($sformatf("rr%0d_done0", k), 32'(bus.done),  32'h0);
      check($sformatf("rr%0d_blank0", k), 32'(bus.blank), 32'h0);
    end

    // Owner 0 expires into owner 1, which then drops early.
    step(HAND);
    check("drop_owner1", 32'(bus.gnt), 32'h2);
    step(5);
    bus.req = 4'b1101;
    step(1);
    check("drop_gnt",  32'(bus.gnt),  32'h0);
    check("drop_done", 32'(bus.done), 32'h1);
    step(HAND - DWELL);
    check("drop_next_gnt", 32'(bus.gnt), 32'h4);
    check("drop_next_src", 32'(bus.src), 32'h2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/disp_share_arb.md
# disp_share_arb

Time-sharing arbiter for the 4-digit 7-segment display driver. Up to N_REQ client blocks request the display, each offering a 16-bit hex word; the arbiter grants one at a time round-robin, holds it for a fixed dwell in milliseconds, and drives the HB/LB byte inputs of the display driver. Optional blank gap between owners makes hand-over visible to the operator.

## Interface
- N_REQ, 4: number of requesters (2..8).
- Fclk, 50000: clock frequency in kHz (= clock cycles per 1 ms tick).
- DWELL_MS, 500: display ownership per grant, in ms.
- GAP_MS, 50: blank gap between owners, in ms (used only with DISP_ARB_GAP_EN).
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  asynchronous reset, active low.
- req  in  N_REQ  per-client request level.
- data  in  16*N_REQ  client words; client i on data[16*i+15:16*i].
- gnt  out  N_REQ  one-hot grant, all zero when no owner.
- src  out  $clog2(N_REQ)  index of current/last owner.
- done  out  1  one-cycle pulse when a grant ends.
- HB  out  8  high byte to display driver.
- LB  out  8  low byte to display driver.
- blank  out  1  display blank request (driver turns all anodes off).
- busy  out  1  high in SHOW or GAP.

## Operation
- Reset (async, rst_n=0): gnt=0, src=0, done=0, HB=0, LB=0, blank=0, busy=0, state IDLE, rotation pointer 0, counters 0.
- States: IDLE, SHOW, GAP (GAP exists only with macro).
- IDLE: if req!=0, pick the first set req at or after pointer, wrapping modulo N_REQ; register gnt, src, {HB,LB}=data[src]; go SHOW; clear ms prescaler and dwell counter. If req==0, stay; HB/LB hold last value.
- SHOW: {HB,LB} re-register data[src] every cycle (live follow). Prescaler counts 1..Fclk, pulses tick at Fclk; dwell counter counts ticks.
- Dwell expiry (DWELL_MS ticks): if req[src] still set and no other req set, keep grant, restart dwell, no done. Otherwise release.
- Early release: req[src] low in SHOW -> release on the next edge.
- Release: gnt=0, done=1 for one cycle, pointer=src+1 (mod N_REQ), go GAP (macro) or IDLE.
- GAP: blank=1; after GAP_MS ticks go IDLE, blank=0.
- Requests from non-owners never pre-empt an active grant.
- Counter widths: prescaler $clog2(Fclk+1), dwell $clog2(max(DWELL_MS,GAP_MS)+1); no wrap possible within range.

## Timing
- req seen in IDLE at edge t -> gnt/src/HB/LB valid after edge t+1 (cycle g).
- Full dwell: gnt falls and done pulses at g+DWELL_MS*Fclk.
- Without gap: IDLE at release cycle, next grant one cycle later.
- With gap: blank high GAP_MS*Fclk cycles starting at release cycle, then one IDLE cycle, then next grant.
- Data change on owner's bus appears on HB/LB one cycle later.
- Early release: req[src] falling seen at edge e -> gnt=0, done=1 after e.
- rst_n low mid-SHOW or mid-GAP: all outputs clear immediately, no done pulse.

## Configuration
- DISP_ARB_GAP_EN defined: GAP state compiled in, blank pulses between owners as above.
- Undefined: no GAP state, GAP_MS ignored, blank tied 0, release goes straight to IDLE.

## Structure
- Shared package disp_pkg: disp_word_t (16-bit), DISP_DIGITS=4, arbiter state enum (IDLE/SHOW/GAP), DISP_BLANK_AN=4'b1111.
- One sub-module: disp_rr_pick — combinational round-robin picker (req, pointer -> one-hot, index, any).
- Prescaler and FSM stay in disp_share_arb.

## Test plan
Bench parameters N_REQ=4, Fclk=4, DWELL_MS=3, GAP_MS=2 (dwell 12 cycles, gap 8).
- Reset: hold rst_n=0 with random req/data -> all outputs 0; release, req=0 -> remains IDLE, busy=0.
- Single client: req=4'b0100, data[2]=16'h1234 -> gnt=4'b0100, src=2, HB=8'h12, LB=8'h34 one cycle later; req held -> grant kept past 12 cycles, no done.
- Round-robin: req=4'b1111 -> owners 0,1,2,3,0; spacing 13 cycles without macro, 21 with; done pulse at each hand-over.
- Early drop: owner 1 drops req 5 cycles into dwell -> gnt=0, done=1 next cycle; next grant goes to client 2 if requesting.
- Live data: owner's word changes 16'hBEEF->16'hCAFE mid-dwell -> HB/LB update one cycle later, gnt unchanged.
- Async reset mid-SHOW: rst_n low between edges -> gnt, HB, LB, blank zero immediately, no done; after release, grant restarts from client 0.
